// File: rtl/vsq_accumulator.sv
// rtl/vsq_accumulator.sv - saturating multi-vector accumulator for VSQ scaled partial sums
// Accumulates num_vec beats, then holds the result on a valid/ready output port.
module vsq_accumulator #(
  parameter int IN_W  = 24,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  partial_sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             beat;
  logic             job_start;

  // One extra bit of headroom exposes the carry used for saturation.
  assign sum       = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, partial_sum_in};
  assign beat      = in_valid && in_ready;
  assign job_start = (state == IDLE) && start;
  assign acc_out   = acc;
  assign overflow  = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_vec == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (count == CNT_W'(1))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (job_start) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= num_vec;
    end else if (beat) begin
      count <= count - 1'b1;
      if (sum[ACC_W]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vsq_accumulator.sv
// tb/tb_vsq_accumulator.sv - directed self-checking bench for vsq_accumulator
// Uses ACC_W=26 so the saturation boundary is reachable with 24-bit beats.
module tb_vsq_accumulator;

  localparam int IN_W  = 24;
  localparam int ACC_W = 26;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  partial_sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  int tests;
  int fails;

  vsq_accumulator #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .partial_sum_in(partial_sum_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .acc_out       (acc_out),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    num_vec = n;
    tick();
    start   = 1'b0;
    num_vec = '0;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] v, input string tag);
    in_valid       = 1'b1;
    partial_sum_in = v;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready: got %b expected 1", tag, in_ready);
    end
    tick();
    in_valid       = 1'b0;
    partial_sum_in = '0;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, overflow, busy} !== 4'b0000 || acc_out !== '0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b busy=%b acc=%0d expected all 0",
               in_ready, out_valid, overflow, busy, acc_out);
    end
  endtask

  task automatic test_basic();
    start_job(8'd4);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_accum_state: got busy=%b vld=%b expected 1/0", busy, out_valid);
    end
    send_beat(24'd100, "basic_b1");
    send_beat(24'd200, "basic_b2");
    send_beat(24'd300, "basic_b3");
    send_beat(24'd400, "basic_b4");
    tests++;
    if (out_valid !== 1'b1 || acc_out !== 26'd1000 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got vld=%b acc=%0d ovf=%b expected 1/1000/0",
               out_valid, acc_out, overflow);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 26'd1000) begin
      fails++;
      $display("FAIL basic_idle: got vld=%b busy=%b acc=%0d expected 0/0/1000",
               out_valid, busy, acc_out);
    end
  endtask

  task automatic test_bubbles();
    start_job(8'd4);
    send_beat(24'd100, "bub_b1");
    send_beat(24'd200, "bub_b2");
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready !== 1'b1 || acc_out !== 26'd300) begin
        fails++;
        $display("FAIL bubble_stall[%0d]: got rdy=%b acc=%0d expected 1/300", i, in_ready, acc_out);
      end
      tick();
    end
    out_ready = 1'b0;
    send_beat(24'd300, "bub_b3");
    send_beat(24'd400, "bub_b4");
    // A fifth beat offered in HOLD must not be consumed.
    in_valid       = 1'b1;
    partial_sum_in = 24'd55;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 26'd1000) begin
      fails++;
      $display("FAIL bubble_result: got vld=%b rdy=%b acc=%0d expected 1/0/1000",
               out_valid, in_ready, acc_out);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (acc_out !== 26'd1000) begin
      fails++;
      $display("FAIL bubble_extra_beat: got acc=%0d expected 1000", acc_out);
    end
    tick();
  endtask

  task automatic test_saturation();
    start_job(8'd5);
    for (int i = 0; i < 4; i++) send_beat(24'hFFFFFF, "sat_beat");
    tests++;
    if (acc_out !== 26'h3FFFFFC || overflow !== 1'b0) begin
      fails++;
      $display("FAIL sat_near_max: got acc=%h ovf=%b expected 3fffffc/0", acc_out, overflow);
    end
    send_beat(24'hFFFFFF, "sat_beat5");
    tests++;
    if (acc_out !== 26'h3FFFFFF || overflow !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL sat_result: got acc=%h ovf=%b vld=%b expected 3ffffff/1/1",
               acc_out, overflow, out_valid);
    end
    tick();
    start_job(8'd2);
    tests++;
    if (overflow !== 1'b0 || acc_out !== '0) begin
      fails++;
      $display("FAIL sat_clear_on_start: got acc=%0d ovf=%b expected 0/0", acc_out, overflow);
    end
    send_beat(24'd1, "sat2_b1");
    send_beat(24'd1, "sat2_b2");
    tests++;
    if (acc_out !== 26'd2 || overflow !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL sat_next_job: got acc=%0d ovf=%b vld=%b expected 2/0/1",
               acc_out, overflow, out_valid);
    end
    tick();
  endtask

  task automatic test_hold_backpressure();
    start_job(8'd2);
    out_ready = 1'b0;
    send_beat(24'd7, "hold_b1");
    send_beat(24'd8, "hold_b2");
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      num_vec = 8'd3;
      tests++;
      if (out_valid !== 1'b1 || acc_out !== 26'd15 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got vld=%b acc=%0d rdy=%b busy=%b expected 1/15/0/1",
                 i, out_valid, acc_out, in_ready, busy);
      end
      tick();
    end
    start     = 1'b0;
    num_vec   = '0;
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 26'd15) begin
      fails++;
      $display("FAIL hold_exit: got vld=%b busy=%b acc=%0d expected 0/0/15", out_valid, busy, acc_out);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_start_ignored: got busy=%b rdy=%b expected 0/0", busy, in_ready);
    end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b0;
    start_job(8'd0);
    tests++;
    if (out_valid !== 1'b1 || acc_out !== '0 || in_ready !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL zero_len: got vld=%b acc=%0d rdy=%b ovf=%b expected 1/0/0/0",
               out_valid, acc_out, in_ready, overflow);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_exit: got vld=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_job();
    start_job(8'd6);
    send_beat(24'd10, "rst_b1");
    send_beat(24'd20, "rst_b2");
    send_beat(24'd30, "rst_b3");
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, overflow, busy} !== 4'b0000 || acc_out !== '0) begin
      fails++;
      $display("FAIL reset_mid_job: got rdy=%b vld=%b ovf=%b busy=%b acc=%0d expected all 0",
               in_ready, out_valid, overflow, busy, acc_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_job(8'd1);
    send_beat(24'd42, "rst_new_b1");
    tests++;
    if (acc_out !== 26'd42 || out_valid !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_fresh_job: got acc=%0d vld=%b ovf=%b expected 42/1/0",
               acc_out, out_valid, overflow);
    end
    tick();
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    num_vec        = '0;
    in_valid       = 1'b0;
    partial_sum_in = '0;
    out_ready      = 1'b1;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_bubbles();
    test_saturation();
    test_hold_backpressure();
    test_zero_len();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
